// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM encodings,
// the NOP returned on a watchdog timeout, and the default timeout limit.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam int          TIMEOUT_DEF = 15;

endpackage

// File: rtl/imem_arb_if.sv
// Bus bundle for the arbiter: two requester syn/ack ports, the memory port,
// flush and status. slave = arbiter side, master = surrounding system.
interface imem_arb_if #(
  parameter int IWIDTH       = 32,
  parameter int AWIDTH_INSTR = 32
);
  logic                    ia_r0_syn;
  logic [AWIDTH_INSTR-1:0] ia_r0_addr;
  logic                    ia_r0_ack;
  logic [IWIDTH-1:0]       ia_r0_instr;

  logic                    ia_r1_syn;
  logic [AWIDTH_INSTR-1:0] ia_r1_addr;
  logic                    ia_r1_ack;
  logic [IWIDTH-1:0]       ia_r1_instr;

  logic                    ia_flush;

  logic                    ia_m_syn;
  logic [AWIDTH_INSTR-1:0] ia_m_addr;
  logic                    ia_m_ack;
  logic [IWIDTH-1:0]       ia_m_instr;

  logic                    ia_o_grant;
  logic                    ia_o_busy;
  logic                    ia_o_err;

  modport slave (
    input  ia_r0_syn, ia_r0_addr, ia_r1_syn, ia_r1_addr, ia_flush,
    input  ia_m_ack, ia_m_instr,
    output ia_r0_ack, ia_r0_instr, ia_r1_ack, ia_r1_instr,
    output ia_m_syn, ia_m_addr, ia_o_grant, ia_o_busy, ia_o_err
  );

  modport master (
    output ia_r0_syn, ia_r0_addr, ia_r1_syn, ia_r1_addr, ia_flush,
    output ia_m_ack, ia_m_instr,
    input  ia_r0_ack, ia_r0_instr, ia_r1_ack, ia_r1_instr,
    input  ia_m_syn, ia_m_addr, ia_o_grant, ia_o_busy, ia_o_err
  );
endinterface

// File: rtl/imem_arb_rr_pick.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes
// to the requester that was not granted last.
module imem_arb_rr_pick (
  input  logic syn0,
  input  logic syn1,
  input  logic last_grant,
  output logic vld,
  output logic winner
);

  assign vld    = syn0 | syn1;
  assign winner = (syn0 & syn1) ? ~last_grant : syn1;

endmodule

// File: rtl/imem_arbiter.sv
// Two-requester arbiter in front of the instruction-memory syn/ack port.
// Optional watchdog on the memory wait is compiled in with IMEM_ARB_TIMEOUT_EN.
import imem_arb_pkg::*;

module imem_arbiter #(
  parameter int IWIDTH       = 32,
  parameter int AWIDTH_INSTR = 32,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic       ia_clk,
  input  logic       ia_rst,
  imem_arb_if.slave  bus
);

  arb_state_e              state;
  logic                    last_grant;
  logic                    drop;
  logic                    pick_vld;
  logic                    pick_win;
  logic                    m_syn;
  logic [AWIDTH_INSTR-1:0] m_addr;
  logic                    grant;
  logic                    busy;
  logic                    err;
  logic                    r0_ack;
  logic                    r1_ack;
  logic [IWIDTH-1:0]       r0_instr;
  logic [IWIDTH-1:0]       r1_instr;

  logic                    flush_hit;
  logic                    resp_fire;
  logic                    tmo_fire;
  logic [IWIDTH-1:0]       resp_data;

  imem_arb_rr_pick u_pick (
    .syn0       (bus.ia_r0_syn),
    .syn1       (bus.ia_r1_syn),
    .last_grant (last_grant),
    .vld        (pick_vld),
    .winner     (pick_win)
  );

  // flush only ever targets an in-flight fetch (owner 0)
  assign flush_hit = bus.ia_flush & ~grant & (state == REQ);

`ifdef IMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
  logic          tmo_exp;

  assign tmo_exp = (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge ia_clk) begin
    if (ia_rst) tmo_cnt <= '0;
    else if (state == REQ && !resp_fire) tmo_cnt <= tmo_cnt + 1'b1;
    else tmo_cnt <= '0;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT != 0);
`endif

  // a real memory ack beats a watchdog expiry in the same cycle
  always_comb begin
    resp_fire = (state == REQ) & bus.ia_m_ack;
    resp_data = bus.ia_m_instr;
    tmo_fire  = 1'b0;
`ifdef IMEM_ARB_TIMEOUT_EN
    if (state == REQ && !bus.ia_m_ack && tmo_exp) begin
      resp_fire = 1'b1;
      resp_data = IWIDTH'(NOP);
      tmo_fire  = 1'b1;
    end
`endif
  end

  always_ff @(posedge ia_clk) begin
    if (ia_rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      drop       <= 1'b0;
      m_syn      <= 1'b0;
      m_addr     <= '0;
      grant      <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_instr   <= '0;
      r1_instr   <= '0;
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state  <= REQ;
            m_syn  <= 1'b1;
            busy   <= 1'b1;
            grant  <= pick_win;
            m_addr <= pick_win ? bus.ia_r1_addr : bus.ia_r0_addr;
            drop   <= 1'b0;
          end
        end
        REQ: begin
          if (flush_hit) drop <= 1'b1;
          if (resp_fire) begin
            state <= RESP;
            m_syn <= 1'b0;
            err   <= tmo_fire;
            if (grant) begin
              r1_ack   <= 1'b1;
              r1_instr <= resp_data;
            end else if (!(drop | flush_hit)) begin
              r0_ack   <= 1'b1;
              r0_instr <= resp_data;
            end
          end
        end
        RESP: begin
          // ack is already on the wire; requester syn is ignored here
          state      <= IDLE;
          busy       <= 1'b0;
          last_grant <= grant;
          drop       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ia_m_syn    = m_syn;
  assign bus.ia_m_addr   = m_addr;
  assign bus.ia_r0_ack   = r0_ack;
  assign bus.ia_r0_instr = r0_instr;
  assign bus.ia_r1_ack   = r1_ack;
  assign bus.ia_r1_instr = r1_instr;
  assign bus.ia_o_grant  = grant;
  assign bus.ia_o_busy   = busy;
`ifdef IMEM_ARB_TIMEOUT_EN
  assign bus.ia_o_err    = err;
`else
  assign bus.ia_o_err    = 1'b0;
  logic unused_err;
  assign unused_err = err;
`endif

endmodule
